mem_arbiter: RTL and testbench

//  Shares one picorv32-style native memory port between NUM_REQ requesters
//  (e.g. two cores, or a core plus a DMA/loader). Round-robin grant, one

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_rr.sv | 44 ++++
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: bus widths, FSM state
// encoding and a wrapping index helper for the round-robin pointer.
package mem_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Combinational rotating-priority picker: first set request at or after the
// pointer (wrapping), returned both one-hot and as an index.
module mem_arbiter_rr #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_req
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    found      = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end else begin
        cand = cand;
      end
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found                = 1'b1;
        win_onehot[cand_idx] = 1'b1;
        win_idx              = cand_idx;
      end else begin
        found = found;
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one picorv32-style native memory port between NUM_REQ requesters:
// round-robin grant, one transaction in flight, watchdog abort.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_instr,
  input  logic [STRB_W*NUM_REQ-1:0]   req_wstrb,
  input  logic [DATA_W*NUM_REQ-1:0]   req_wdata,
  input  logic [DATA_W*NUM_REQ-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W*NUM_REQ-1:0]   req_rdata,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        mem_valid,
  output logic                        mem_instr,
  output logic [STRB_W-1:0]           mem_wstrb,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [DATA_W-1:0]           mem_addr,
  input  logic                        mem_ready,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit WD_ON = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] WD_LAST = WD_ON ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t                      state, state_nxt;
  logic [IDX_W-1:0]            ptr, ptr_nxt;
  logic [CNT_W-1:0]            wd_cnt, wd_cnt_nxt;
  logic [NUM_REQ-1:0]          win_onehot;
  logic [IDX_W-1:0]            win_idx;
  logic                        any_req;
  logic                        wd_expire;
  logic [DATA_W-1:0]           resp_data;

  logic                        sel_instr;
  logic [STRB_W-1:0]           sel_wstrb;
  logic [DATA_W-1:0]           sel_wdata;
  logic [DATA_W-1:0]           sel_addr;

  logic [NUM_REQ-1:0]          grant_nxt, req_ready_nxt;
  logic [DATA_W*NUM_REQ-1:0]   req_rdata_nxt;
  logic                        mem_valid_nxt, mem_instr_nxt, timeout_err_nxt;
  logic [STRB_W-1:0]           mem_wstrb_nxt;
  logic [DATA_W-1:0]           mem_wdata_nxt, mem_addr_nxt;

  mem_arbiter_rr #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .ptr        (ptr),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .any_req    (any_req)
  );

  // An aborted transaction returns zero data rather than whatever is on the bus.
  assign wd_expire = WD_ON && (wd_cnt == WD_LAST);
  assign resp_data = mem_ready ? mem_rdata : 32'h0000_0000;

  // One-hot OR-mux of the winning requester's command fields.
  always_comb begin
    sel_instr = 1'b0;
    sel_wstrb = '0;
    sel_wdata = '0;
    sel_addr  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_instr = sel_instr | (req_instr[i] & win_onehot[i]);
      sel_wstrb = sel_wstrb | (req_wstrb[STRB_W*i +: STRB_W] & {STRB_W{win_onehot[i]}});
      sel_wdata = sel_wdata | (req_wdata[DATA_W*i +: DATA_W] & {DATA_W{win_onehot[i]}});
      sel_addr  = sel_addr  | (req_addr[DATA_W*i +: DATA_W]  & {DATA_W{win_onehot[i]}});
    end
  end

  // State and all output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      wd_cnt      <= '0;
      grant       <= '0;
      req_ready   <= '0;
      req_rdata   <= '0;
      mem_valid   <= 1'b0;
      mem_instr   <= 1'b0;
      mem_wstrb   <= '0;
      mem_wdata   <= '0;
      mem_addr    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      wd_cnt      <= wd_cnt_nxt;
      grant       <= grant_nxt;
      req_ready   <= req_ready_nxt;
      req_rdata   <= req_rdata_nxt;
      mem_valid   <= mem_valid_nxt;
      mem_instr   <= mem_instr_nxt;
      mem_wstrb   <= mem_wstrb_nxt;
      mem_wdata   <= mem_wdata_nxt;
      mem_addr    <= mem_addr_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

  // Next-state logic; mem_ready outside BUSY has no effect.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_nxt = ST_BUSY;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ready || wd_expire) begin
          state_nxt = ST_RESP;
        end else begin
          state_nxt = ST_BUSY;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the transition taken.
  always_comb begin
    ptr_nxt         = ptr;
    wd_cnt_nxt      = '0;
    grant_nxt       = grant;
    req_ready_nxt   = '0;
    req_rdata_nxt   = '0;
    mem_valid_nxt   = 1'b0;
    mem_instr_nxt   = mem_instr;
    mem_wstrb_nxt   = mem_wstrb;
    mem_wdata_nxt   = mem_wdata;
    mem_addr_nxt    = mem_addr;
    timeout_err_nxt = timeout_err;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          grant_nxt     = win_onehot;
          ptr_nxt       = IDX_W'(wrap_next(32'(win_idx), 32'(NUM_REQ)));
          mem_valid_nxt = 1'b1;
          mem_instr_nxt = sel_instr;
          mem_wstrb_nxt = sel_wstrb;
          mem_wdata_nxt = sel_wdata;
          mem_addr_nxt  = sel_addr;
        end else begin
          grant_nxt = '0;
        end
      end
      ST_BUSY: begin
        if (state_nxt == ST_RESP) begin
          req_ready_nxt   = grant;
          timeout_err_nxt = timeout_err | ~mem_ready;
          for (int i = 0; i < NUM_REQ; i++) begin
            req_rdata_nxt[DATA_W*i +: DATA_W] = grant[i] ? resp_data : 32'h0000_0000;
          end
        end else begin
          mem_valid_nxt = 1'b1;
          wd_cnt_nxt    = WD_ON ? (wd_cnt + CNT_W'(1)) : '0;
        end
      end
      ST_RESP: grant_nxt = '0;
      default: grant_nxt = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (two requesters, 8-cycle watchdog).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_instr;
  logic [7:0]  req_wstrb;
  logic [63:0] req_wdata;
  logic [63:0] req_addr;
  logic [1:0]  req_ready;
  logic [63:0] req_rdata;
  logic [1:0]  grant;
  logic        mem_valid;
  logic        mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_instr   (req_instr),
    .req_wstrb   (req_wstrb),
    .req_wdata   (req_wdata),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .req_rdata   (req_rdata),
    .grant       (grant),
    .mem_valid   (mem_valid),
    .mem_instr   (mem_instr),
    .mem_wstrb   (mem_wstrb),
    .mem_wdata   (mem_wdata),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 2'b00; req_instr = 2'b00; req_wstrb = 8'h00;
    req_wdata = 64'h0; req_addr = 64'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    step(); step();
    reset = 1'b0;
    tests++; if (grant !== 2'b00) begin fails++; $display("FAIL reset_grant: got %b, expected 00", grant); end
    tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_valid: got %b, expected 0", mem_valid); end
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready: got %b, expected 00", req_ready); end
    tests++; if (req_rdata !== 64'h0) begin fails++; $display("FAIL reset_req_rdata: got %h, expected 0", req_rdata); end
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout_err: got %b, expected 0", timeout_err); end
    tests++; if ({mem_instr, mem_wstrb, mem_wdata, mem_addr} !== 69'h0) begin fails++; $display("FAIL reset_mem_bus: got %h/%h/%h, expected 0", mem_wstrb, mem_wdata, mem_addr); end
  endtask

  task automatic test_single_read();
    req_valid = 2'b01; req_instr = 2'b01; req_addr = 64'h0000_0000_0000_0100;
    step();
    tests++; if (grant !== 2'b01) begin fails++; $display("FAIL read_grant: got %b, expected 01", grant); end
    tests++; if (mem_valid !== 1'b1 || mem_addr !== 32'h100 || mem_instr !== 1'b1) begin fails++; $display("FAIL read_mem_cmd: got v=%b a=%h i=%b, expected v=1 a=00000100 i=1", mem_valid, mem_addr, mem_instr); end
    step();
    tests++; if (mem_valid !== 1'b1 || req_ready !== 2'b00) begin fails++; $display("FAIL read_busy2: got v=%b rdy=%b, expected v=1 rdy=00", mem_valid, req_ready); end
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ready = 1'b0; mem_rdata = 32'h0; req_valid = 2'b00;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL read_ready: got %b, expected 01", req_ready); end
    tests++; if (req_rdata !== 64'h0000_0000_DEAD_BEEF) begin fails++; $display("FAIL read_rdata: got %h, expected 00000000deadbeef", req_rdata); end
    tests++; if (mem_valid !== 1'b0 || grant !== 2'b01) begin fails++; $display("FAIL read_resp_state: got v=%b g=%b, expected v=0 g=01", mem_valid, grant); end
    step();
    tests++; if (req_ready !== 2'b00 || grant !== 2'b00) begin fails++; $display("FAIL read_idle: got rdy=%b g=%b, expected 00/00", req_ready, grant); end
  endtask

  task automatic test_write();
    req_valid = 2'b10; req_instr = 2'b00; req_wstrb = 8'b0011_0000;
    req_wdata = 64'h1234_5678_0000_0000; req_addr = 64'h0000_0200_0000_0000;
    step();
    tests++; if (grant !== 2'b10) begin fails++; $display("FAIL write_grant: got %b, expected 10", grant); end
    // Scramble and drop the request: the latched command must not move.
    req_valid = 2'b00; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_addr = 64'h0; req_wstrb = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (mem_valid !== 1'b1 || mem_wstrb !== 4'b0011 || mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h200 || mem_instr !== 1'b0) begin
        fails++; $display("FAIL write_hold%0d: got v=%b s=%b d=%h a=%h, expected v=1 s=0011 d=12345678 a=00000200", k, mem_valid, mem_wstrb, mem_wdata, mem_addr);
      end
      if (k < 3) step();
    end
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
    step();
    mem_ready = 1'b0;
    tests++; if (req_ready !== 2'b10 || req_rdata !== 64'hCAFE_0001_0000_0000) begin fails++; $display("FAIL write_resp: got rdy=%b d=%h, expected 10/cafe000100000000", req_ready, req_rdata); end
    step();
    tests++; if (req_ready !== 2'b00 || grant !== 2'b00) begin fails++; $display("FAIL write_idle: got rdy=%b g=%b, expected 00/00", req_ready, grant); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_g;
    logic [63:0] exp_d;
    req_valid = 2'b11; req_instr = 2'b11; req_wstrb = 8'h00;
    req_addr = 64'h0000_0B00_0000_0A00;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      step();
      tests++; if (grant !== exp_g) begin fails++; $display("FAIL rr_grant%0d: got %b, expected %b", k, grant, exp_g); end
      mem_ready = 1'b1; mem_rdata = 32'h1000 + 32'(k);
      step();
      mem_ready = 1'b0;
      exp_d = (k % 2 == 0) ? {32'h0, 32'h1000 + 32'(k)} : {32'h1000 + 32'(k), 32'h0};
      tests++; if (req_ready !== exp_g || req_rdata !== exp_d) begin fails++; $display("FAIL rr_resp%0d: got rdy=%b d=%h, expected %b/%h", k, req_ready, req_rdata, exp_g, exp_d); end
      step();
      tests++; if (req_ready !== 2'b00 || grant !== 2'b00) begin fails++; $display("FAIL rr_idle%0d: got rdy=%b g=%b, expected 00/00", k, req_ready, grant); end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_timeout();
    req_valid = 2'b01; req_addr = 64'h0000_0000_0000_0300;
    step();
    req_valid = 2'b00; mem_rdata = 32'h55AA_55AA;
    tests++; if (grant !== 2'b01 || mem_valid !== 1'b1) begin fails++; $display("FAIL to_grant: got g=%b v=%b, expected 01/1", grant, mem_valid); end
    // Seven more BUSY cycles without completion (eight in total).
    for (int k = 0; k < 7; k++) begin
      step();
      tests++; if (mem_valid !== 1'b1 || req_ready !== 2'b00) begin fails++; $display("FAIL to_busy%0d: got v=%b rdy=%b, expected 1/00", k, mem_valid, req_ready); end
    end
    step();
    tests++; if (req_ready !== 2'b01 || req_rdata !== 64'h0 || mem_valid !== 1'b0) begin fails++; $display("FAIL to_abort: got rdy=%b d=%h v=%b, expected 01/0/0", req_ready, req_rdata, mem_valid); end
    tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_err_set: got %b, expected 1", timeout_err); end
    step();
    tests++; if (timeout_err !== 1'b1 || req_ready !== 2'b00) begin fails++; $display("FAIL to_err_sticky: got e=%b rdy=%b, expected 1/00", timeout_err, req_ready); end
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    tests++; if (grant !== 2'b10) begin fails++; $display("FAIL to_next_grant: got %b, expected 10", grant); end
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_ready = 1'b0;
    tests++; if (req_ready !== 2'b10 || req_rdata !== 64'h0BAD_F00D_0000_0000 || timeout_err !== 1'b1) begin fails++; $display("FAIL to_next_resp: got rdy=%b d=%h e=%b, expected 10/0badf00d00000000/1", req_ready, req_rdata, timeout_err); end
    step();
  endtask

  task automatic test_reset_busy();
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    tests++; if (mem_valid !== 1'b1) begin fails++; $display("FAIL rb_busy: got %b, expected 1", mem_valid); end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++; if (mem_valid !== 1'b0 || grant !== 2'b00 || req_ready !== 2'b00 || timeout_err !== 1'b0) begin fails++; $display("FAIL rb_cleared: got v=%b g=%b rdy=%b e=%b, expected 0/00/00/0", mem_valid, grant, req_ready, timeout_err); end
    mem_ready = 1'b1; mem_rdata = 32'h1212_1212;
    for (int k = 0; k < 2; k++) begin
      step();
      tests++; if (req_ready !== 2'b00 || grant !== 2'b00 || mem_valid !== 1'b0) begin fails++; $display("FAIL rb_late_ready%0d: got rdy=%b g=%b v=%b, expected 00/00/0", k, req_ready, grant, mem_valid); end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_idle_ready();
    mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if (req_ready !== 2'b00 || grant !== 2'b00 || mem_valid !== 1'b0 || req_rdata !== 64'h0) begin fails++; $display("FAIL idle_ready%0d: got rdy=%b g=%b v=%b, expected 00/00/0", k, req_ready, grant, mem_valid); end
    end
    mem_ready = 1'b0;
    // Pointer must still favour requester 0 after the stray readies.
    req_valid = 2'b11;
    step();
    req_valid = 2'b00;
    tests++; if (grant !== 2'b01) begin fails++; $display("FAIL idle_ptr: got %b, expected 01", grant); end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_timeout();
    test_reset_busy();
    test_idle_ready();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
